// File: rtl/phy_pkg.sv
// Shared constants for the PHY symbol path.
//   BITS_QAM16 / BITS_QPSK                 : bits carried per symbol in each mode
//   SYM_PER_BYTE_QAM16 / SYM_PER_BYTE_QPSK : symbols needed to drain one byte
//   SCR_SEED_DEFAULT                       : power-up / reload value of the scrambler LFSR
package phy_pkg;

  localparam int         BITS_QAM16         = 4;
  localparam int         BITS_QPSK          = 2;
  localparam int         SYM_PER_BYTE_QAM16 = 2;
  localparam int         SYM_PER_BYTE_QPSK  = 4;
  localparam logic [6:0] SCR_SEED_DEFAULT   = 7'h7F;

endpackage

// File: rtl/phy_scrambler8.sv
// Byte-wide additive scrambler built on a 7-bit LFSR (x^7 + x^4 + 1).
// Each byte is XORed with 8 successive LFSR outputs (out = s7 ^ s4), output k
// going to bit k, bit 0 first.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset (LFSR returns to SEED)
//   load       : restart the sequence from SEED this cycle (applies to byte_o too)
//   advance    : commit the 8-step advance (one byte consumed)
//   byte_i     : plain byte
//   byte_o     : scrambled byte (combinational)
module phy_scrambler8 import phy_pkg::*; #(
  parameter logic [6:0] SEED = SCR_SEED_DEFAULT
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       advance,
  input  logic [7:0] byte_i,
  output logic [7:0] byte_o
);

  logic [6:0] lfsr_q;
  logic [6:0] lfsr_d;
  logic [6:0] lfsr_cur;
  logic [6:0] lfsr_walk;
  logic       key_bit;

  always_comb begin
    // A reload coinciding with an accept must scramble that byte from the seed.
    lfsr_cur  = load ? SEED : lfsr_q;
    lfsr_walk = lfsr_cur;
    key_bit   = 1'b0;
    byte_o    = byte_i;
    for (int k = 0; k < 8; k++) begin
      key_bit   = lfsr_walk[6] ^ lfsr_walk[3];
      byte_o[k] = byte_i[k] ^ key_bit;
      lfsr_walk = {lfsr_walk[5:0], key_bit};
    end
    lfsr_d = advance ? lfsr_walk : lfsr_cur;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_q <= SEED;
    else        lfsr_q <= lfsr_d;
  end

endmodule

// File: rtl/bit_grouper.sv
// Splits accepted bytes into mapper symbols: 4-bit groups (16-QAM) or 2-bit
// groups (QPSK), LSB first, over Wishbone-style handshakes on both sides.
// Optional feature: define SCRAMBLER_EN to scramble each accepted byte with
// phy_scrambler8 (LFSR reloaded with SCR_SEED on every rising edge of CYC_I).
// Ports:
//   CLK_I, RST_I          : clock, asynchronous active-low reset
//   DAT_I, CYC_I, STB_I,
//   WE_I, ACK_O           : upstream byte interface
//   QAM                   : 1 = 16-QAM, 0 = QPSK (sampled per byte)
//   DAT_O, CYC_O, STB_O,
//   WE_O, ACK_I           : downstream symbol interface
module bit_grouper import phy_pkg::*; #(
  parameter logic [6:0] SCR_SEED = SCR_SEED_DEFAULT
) (
  input  logic       CLK_I,
  input  logic       RST_I,
  input  logic [7:0] DAT_I,
  input  logic       CYC_I,
  input  logic       STB_I,
  input  logic       WE_I,
  output logic       ACK_O,
  input  logic       QAM,
  output logic [3:0] DAT_O,
  output logic       CYC_O,
  output logic       STB_O,
  output logic       WE_O,
  input  logic       ACK_I
);

  logic [7:0] buf_q,  buf_d;
  logic [2:0] cnt_q,  cnt_d;
  logic       mode_q, mode_d;
  logic       cyc_o_q, cyc_o_d;
  logic [7:0] load_byte;
  logic       accept;

  // A new byte fits when empty, or when the last symbol leaves this same cycle.
  assign accept = CYC_I & STB_I & WE_I &
                  ((cnt_q == 3'd0) | ((cnt_q == 3'd1) & ACK_I));

`ifdef SCRAMBLER_EN
  logic cyc_prev_q;

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) cyc_prev_q <= 1'b0;
    else        cyc_prev_q <= CYC_I;
  end

  phy_scrambler8 #(.SEED(SCR_SEED)) u_scrambler (
    .clk     (CLK_I),
    .rst_n   (RST_I),
    .load    (CYC_I & ~cyc_prev_q),
    .advance (accept),
    .byte_i  (DAT_I),
    .byte_o  (load_byte)
  );
`else
  logic [6:0] unused_seed;
  assign unused_seed = SCR_SEED;
  assign load_byte   = DAT_I;
`endif

  always_comb begin
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    cyc_o_d = CYC_I | (cnt_q != 3'd0);
    // Load wins over shift so a back-to-back byte follows with no bubble.
    if (accept) begin
      buf_d  = load_byte;
      mode_d = QAM;
      cnt_d  = QAM ? 3'(SYM_PER_BYTE_QAM16) : 3'(SYM_PER_BYTE_QPSK);
    end else if ((cnt_q != 3'd0) && ACK_I) begin
      buf_d = mode_q ? (buf_q >> BITS_QAM16) : (buf_q >> BITS_QPSK);
      cnt_d = cnt_q - 3'd1;
    end
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      buf_q   <= 8'h00;
      cnt_q   <= 3'd0;
      mode_q  <= 1'b1;
      cyc_o_q <= 1'b0;
    end else begin
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
      cyc_o_q <= cyc_o_d;
    end
  end

  assign ACK_O = accept;
  assign STB_O = (cnt_q != 3'd0);
  assign WE_O  = STB_O;
  assign CYC_O = cyc_o_q;
  assign DAT_O = mode_q ? buf_q[3:0] : {2'b00, buf_q[1:0]};

endmodule

// File: tb/tb_bit_grouper.sv
module tb_bit_grouper;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] dat_i;
  logic       cyc_i, stb_i, we_i, ack_i, qam;
  logic       ack_o, cyc_o, stb_o, we_o;
  logic [3:0] dat_o;

  int total = 0;
  int bad   = 0;

  localparam logic [6:0] SEED = 7'h7F;

  bit_grouper #(.SCR_SEED(SEED)) dut (
    .CLK_I (clk),   .RST_I (rst_n), .DAT_I (dat_i), .CYC_I (cyc_i),
    .STB_I (stb_i), .WE_I  (we_i),  .ACK_O (ack_o), .QAM   (qam),
    .DAT_O (dat_o), .CYC_O (cyc_o), .STB_O (stb_o), .WE_O  (we_o),
    .ACK_I (ack_i)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0; ack_i = 1'b1; qam = 1'b1; dat_i = 8'h00;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    idle_inputs();
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    #3;
    total++; if (stb_o !== 1'b0) begin bad++; $display("FAIL reset_stb got=%b exp=0", stb_o); end
    total++; if (cyc_o !== 1'b0) begin bad++; $display("FAIL reset_cyc got=%b exp=0", cyc_o); end
    total++; if (dat_o !== 4'h0) begin bad++; $display("FAIL reset_dat got=%h exp=0", dat_o); end
    total++; if (we_o  !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", we_o); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
    total++; if (stb_o !== 1'b0) begin bad++; $display("FAIL post_reset_stb got=%b exp=0", stb_o); end
  endtask

  task automatic test_qam16();
    logic [3:0] exp_sym [2] = '{4'h5, 4'hA};
    do_reset();
    @(posedge clk); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = 8'hA5; qam = 1'b1; ack_i = 1'b1;
    @(negedge clk);
    total++; if (ack_o !== 1'b1) begin bad++; $display("FAIL qam16_ack got=%b exp=1", ack_o); end
    total++; if (stb_o !== 1'b0) begin bad++; $display("FAIL qam16_latency got=%b exp=0", stb_o); end
    @(posedge clk); #1; stb_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (stb_o !== 1'b1 || dat_o !== exp_sym[i])
        begin bad++; $display("FAIL qam16_sym%0d got=%b/%h exp=1/%h", i, stb_o, dat_o, exp_sym[i]); end
      @(posedge clk);
    end
    @(negedge clk);
    total++; if (stb_o !== 1'b0) begin bad++; $display("FAIL qam16_drained got=%b exp=0", stb_o); end
    total++; if (cyc_o !== 1'b1) begin bad++; $display("FAIL qam16_cyc got=%b exp=1", cyc_o); end
    cyc_i = 1'b0;
  endtask

  task automatic test_qpsk();
    do_reset();
    @(posedge clk); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = 8'hE4; qam = 1'b0; ack_i = 1'b1;
    @(posedge clk); #1; stb_i = 1'b0; qam = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (stb_o !== 1'b1 || dat_o !== 4'(i))
        begin bad++; $display("FAIL qpsk_sym%0d got=%b/%h exp=1/%h", i, stb_o, dat_o, 4'(i)); end
      @(posedge clk);
    end
    @(negedge clk);
    total++; if (stb_o !== 1'b0) begin bad++; $display("FAIL qpsk_drained got=%b exp=0", stb_o); end
    cyc_i = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    @(posedge clk); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = 8'hA5; qam = 1'b1; ack_i = 1'b1;
    @(posedge clk); #1; ack_i = 1'b0; dat_i = 8'h3C;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      total++; if (stb_o !== 1'b1 || dat_o !== 4'h5 || ack_o !== 1'b0)
        begin bad++; $display("FAIL bp_hold%0d got=stb%b dat%h ack%b exp=stb1 dat5 ack0", i, stb_o, dat_o, ack_o); end
      @(posedge clk); #1;
    end
    stb_i = 1'b0; ack_i = 1'b1;
    @(negedge clk);
    total++; if (dat_o !== 4'h5) begin bad++; $display("FAIL bp_release0 got=%h exp=5", dat_o); end
    @(posedge clk); @(negedge clk);
    total++; if (dat_o !== 4'hA) begin bad++; $display("FAIL bp_release1 got=%h exp=a", dat_o); end
    cyc_i = 1'b0;
  endtask

  task automatic test_back_to_back();
    do_reset();
    @(posedge clk); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = 8'h21; qam = 1'b1; ack_i = 1'b1;
    @(posedge clk); #1; dat_i = 8'h43;
    @(negedge clk);
    total++; if (stb_o !== 1'b1 || dat_o !== 4'h1) begin bad++; $display("FAIL b2b_sym0 got=%b/%h exp=1/1", stb_o, dat_o); end
    @(posedge clk); #1;
    @(negedge clk);
    total++; if (stb_o !== 1'b1 || dat_o !== 4'h2) begin bad++; $display("FAIL b2b_sym1 got=%b/%h exp=1/2", stb_o, dat_o); end
    total++; if (ack_o !== 1'b1) begin bad++; $display("FAIL b2b_ack got=%b exp=1", ack_o); end
    @(posedge clk); #1; stb_i = 1'b0;
    @(negedge clk);
    total++; if (stb_o !== 1'b1 || dat_o !== 4'h3) begin bad++; $display("FAIL b2b_sym2 got=%b/%h exp=1/3", stb_o, dat_o); end
    @(posedge clk); @(negedge clk);
    total++; if (stb_o !== 1'b1 || dat_o !== 4'h4) begin bad++; $display("FAIL b2b_sym3 got=%b/%h exp=1/4", stb_o, dat_o); end
    @(posedge clk); @(negedge clk);
    total++; if (stb_o !== 1'b0) begin bad++; $display("FAIL b2b_drained got=%b exp=0", stb_o); end
    cyc_i = 1'b0;
  endtask

  task automatic test_reset_mid_byte();
    do_reset();
    @(posedge clk); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = 8'hE4; qam = 1'b0; ack_i = 1'b1;
    @(posedge clk); #1; stb_i = 1'b0;
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++; if (stb_o !== 1'b0) begin bad++; $display("FAIL midrst_stb got=%b exp=0", stb_o); end
    total++; if (cyc_o !== 1'b0) begin bad++; $display("FAIL midrst_cyc got=%b exp=0", cyc_o); end
    cyc_i = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      total++; if (stb_o !== 1'b0) begin bad++; $display("FAIL midrst_stale%0d got=%b exp=0", i, stb_o); end
    end
  endtask

`ifdef SCRAMBLER_EN
  task automatic test_scrambler();
    do_reset();
    @(posedge clk); #1;
    cyc_i = 1'b1; stb_i = 1'b1; we_i = 1'b1; dat_i = 8'h00; qam = 1'b1; ack_i = 1'b1;
    @(posedge clk); #1; stb_i = 1'b0;
    @(negedge clk);
    total++; if (dat_o !== 4'h0) begin bad++; $display("FAIL scr_sym0 got=%h exp=0", dat_o); end
    @(posedge clk); @(negedge clk);
    total++; if (dat_o !== 4'h7) begin bad++; $display("FAIL scr_sym1 got=%h exp=7", dat_o); end
    cyc_i = 1'b0;
  endtask
`endif

  // Reference: a queue of pending symbols, filled whole-byte at acceptance.
  task automatic test_random();
    logic [3:0] q[$];
    logic       c_cyc, c_stb, c_we, c_ack, c_qam;
    logic [7:0] c_dat, byte_v;
    logic       exp_ack, exp_cyc_o;
    int         bps, nsym;
`ifdef SCRAMBLER_EN
    logic [6:0] m_lfsr = SEED;
    logic       m_cyc_prev = 1'b0;
    logic       ks;
`endif
    exp_cyc_o = 1'b0;
    do_reset();
    @(posedge clk);
    for (int n = 0; n < 600; n++) begin
      #1;
      cyc_i = ($urandom_range(0, 7) != 0);
      stb_i = ($urandom_range(0, 3) != 0);
      we_i  = ($urandom_range(0, 7) != 0);
      ack_i = ($urandom_range(0, 3) != 0);
      qam   = $urandom_range(0, 1);
      dat_i = 8'($urandom);
      @(negedge clk);
      c_cyc = cyc_i; c_stb = stb_i; c_we = we_i; c_ack = ack_i; c_qam = qam; c_dat = dat_i;
      exp_ack = c_cyc && c_stb && c_we && (q.size() == 0 || (q.size() == 1 && c_ack));
      total++; if (ack_o !== exp_ack) begin bad++; $display("FAIL rnd_ack n=%0d got=%b exp=%b", n, ack_o, exp_ack); end
      total++; if (stb_o !== (q.size() != 0) || we_o !== (q.size() != 0))
        begin bad++; $display("FAIL rnd_stb n=%0d got=%b/%b exp=%b", n, stb_o, we_o, q.size() != 0); end
      total++; if (cyc_o !== exp_cyc_o) begin bad++; $display("FAIL rnd_cyc n=%0d got=%b exp=%b", n, cyc_o, exp_cyc_o); end
      if (q.size() != 0) begin
        total++; if (dat_o !== q[0]) begin bad++; $display("FAIL rnd_dat n=%0d got=%h exp=%h", n, dat_o, q[0]); end
      end
      @(posedge clk);
      exp_cyc_o = c_cyc || (q.size() != 0);
      if (c_ack && q.size() != 0) void'(q.pop_front());
      byte_v = c_dat;
`ifdef SCRAMBLER_EN
      if (c_cyc && !m_cyc_prev) m_lfsr = SEED;
      m_cyc_prev = c_cyc;
      if (exp_ack) begin
        for (int k = 0; k < 8; k++) begin
          ks = m_lfsr[6] ^ m_lfsr[3];
          byte_v[k] = byte_v[k] ^ ks;
          m_lfsr = {m_lfsr[5:0], ks};
        end
      end
`endif
      if (exp_ack) begin
        bps  = c_qam ? 4 : 2;
        nsym = 8 / bps;
        for (int s = 0; s < nsym; s++)
          q.push_back(4'((byte_v >> (s * bps)) & ((1 << bps) - 1)));
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_qam16();
    test_qpsk();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_byte();
`ifdef SCRAMBLER_EN
    test_scrambler();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
